adc_responder: RTL and testbench
================================

ADC_RESPONDER -- requirements
Module: adc_responder

Interface
REQ-001 Parameter TCONV_CYCLES, default 80, i_clk cycles from detected convst rise to conversion complete (1.6 us at 50 MHz).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on i_convst, i_sck, i_serial_tx (legal 2-3).
REQ-003 i_clk  in  1  system clock; all logic on rising edge.
REQ-004 i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_sample  in  12  analog value to report; captured at conversion start.
REQ-006 i_convst  in  1  conversion start from the ADC controller (asynchronous).
REQ-007 i_sck  in  1  serial clock from the controller (asynchronous).
REQ-008 i_serial_tx  in  1  controller-to-ADC config data, MSB first.
REQ-009 o_serial_rx  out  1  ADC-to-controller data, MSB first.
REQ-010 o_cfg_bits  out  6  last complete configuration word.
REQ-011 o_cfg_dv  out  1  one-cycle pulse when o_cfg_bits updates.
REQ-012 o_busy  out  1  high while converting.
REQ-013 o_tconv_err  out  1  sticky: convst fell before conversion complete.

Function
REQ-014 All three async inputs SHALL pass through SYNC_STAGES flops; edge detection uses last two synchronized samples.
REQ-015 States: IDLE, CONVERTING, READY, SHIFTING.
REQ-016 Convst rising edge, in any state: capture i_sample into 12-bit shift register, clear bit counters, clear o_tconv_err, load conversion counter, enter CONVERTING.
REQ-017 CONVERTING: o_busy=1; counter counts TCONV_CYCLES cycles, then READY; sck edges ignored; o_serial_rx=0.
REQ-018 READY: o_busy=0; on convst falling edge enter SHIFTING.
REQ-019 Convst falling edge in CONVERTING: set o_tconv_err, o_busy=0, enter SHIFTING with captured sample.
REQ-020 Entering SHIFTING: o_serial_rx SHALL present sample bit 11 within 1 cycle.
REQ-021 SHIFTING, sck rising edge: increment 4-bit rise counter (saturate at 12); for rises 1-6 shift synchronized i_serial_tx into config shift register (first bit lands in bit 5).
REQ-022 SHIFTING, sck falling edge: increment fall counter; falls 1-11 shift data register left, o_serial_rx = next bit (bit 11-n after fall n).
REQ-023 Falling edge with no prior rise in the frame SHALL be ignored (no shift).
REQ-024 6th rise: o_cfg_bits updated and o_cfg_dv pulses one cycle on the following cycle.
REQ-025 12th fall: o_serial_rx=0, return to IDLE.
REQ-026 Rises beyond 12 or sck edges in IDLE/READY: ignored, o_serial_rx=0.
REQ-027 Convst rising mid-SHIFTING aborts the frame per REQ-016; partial config (<6 bits) discarded, no o_cfg_dv.
REQ-028 Simultaneous convst edge and sck edge in one cycle: convst edge wins; sck edge dropped.
REQ-029 Worst-case path input-pin-to-o_serial_rx change: SYNC_STAGES+2 cycles; controllers SHALL sample no earlier than that after sck fall.

Reset
REQ-030 While i_rst_n=0: state IDLE, all counters and shift registers 0, synchronizers 0, o_serial_rx=0, o_cfg_bits=0, o_cfg_dv=0, o_busy=0, o_tconv_err=0.
REQ-031 Reset deassertion mid-frame: resume in IDLE; first action requires a fresh convst rise.
REQ-032 Convst already high at reset release SHALL NOT trigger a conversion (synchronizers reset to 0 yield a rise only after sampling 1 — must be masked for SYNC_STAGES+1 cycles).

Verification
REQ-033 i_sample=12'hA5C, convst high 101 cycles, 12 sck periods of 50 cycles (rise at 25), sdi 6'b101101 -> controller reads 12'hA5C, o_cfg_bits=6'b101101, one o_cfg_dv pulse, o_tconv_err=0.
REQ-034 Convst high only 40 cycles, same frame, i_sample=12'h3FF -> o_tconv_err=1, data 12'h3FF still shifted, o_busy drops at convst fall.
REQ-035 Convst rise after 4 sck periods -> no o_cfg_dv, o_cfg_bits unchanged, new conversion with current i_sample.
REQ-036 i_rst_n low during CONVERTING for 3 cycles -> all outputs 0, 20 sck edges with convst low -> o_serial_rx stays 0.
REQ-037 16 sck periods after convst fall, i_sample=12'hFFF -> 12 ones then o_serial_rx=0, exactly one o_cfg_dv, state IDLE.
REQ-038 i_sample changed 1 cycle after convst rise -> reported value is the pre-change sample.

Source files
------------

// File: rtl/adc_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// | Module : adc_responder_if                                               |
// | Desc   : Serial ADC link between controller (master) and ADC (slave).   |
// |          convst/sck/serial_tx are driven by the controller, serial_rx   |
// |          by the ADC model.                                              |
// | Rev    : 1.0  initial release                                           |
// ---------------------------------------------------------------------------
interface adc_responder_if;
  logic convst;
  logic sck;
  logic serial_tx;
  logic serial_rx;

  modport master (
    output convst,
    output sck,
    output serial_tx,
    input  serial_rx
  );

  modport slave (
    input  convst,
    input  sck,
    input  serial_tx,
    output serial_rx
  );
endinterface
`default_nettype wire

// File: rtl/adc_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// | Module : adc_responder                                                  |
// | Desc   : Behavioural SAR-ADC responder. Captures a 12-bit sample on a   |
// |          convst rise, models the conversion time, then shifts the       |
// |          sample out MSB first on sck falls while receiving a 6-bit      |
// |          configuration word on the first six sck rises.                 |
// | Rev    : 1.0  initial release                                           |
// ---------------------------------------------------------------------------
module adc_responder #(
  parameter int TCONV_CYCLES = 80,
  parameter int SYNC_STAGES  = 2
) (
  input  wire logic        i_clk,
  input  wire logic        i_rst_n,
  input  wire logic [11:0] i_sample,
  adc_responder_if.slave   bus,
  output logic      [5:0]  o_cfg_bits,
  output logic             o_cfg_dv,
  output logic             o_busy,
  output logic             o_tconv_err
);

  localparam int c_CNT_W      = $clog2(TCONV_CYCLES + 1);
  localparam int c_ARM_CYCLES = SYNC_STAGES + 1;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_CONVERTING = 2'd1,
    S_READY      = 2'd2,
    S_SHIFTING   = 2'd3
  } state_t;

  state_t                   r_state;
  logic [SYNC_STAGES-1:0]   r_convst_sync;
  logic [SYNC_STAGES-1:0]   r_sck_sync;
  logic [SYNC_STAGES-1:0]   r_tx_sync;
  logic                     r_convst_d;
  logic                     r_sck_d;
  logic [2:0]               r_arm_cnt;
  logic [11:0]              r_sample_pipe [SYNC_STAGES];
  logic [11:0]              r_data;
  logic [5:0]               r_cfg_sr;
  logic                     r_cfg_pend;
  logic [3:0]               r_rise_cnt;
  logic [3:0]               r_fall_cnt;
  logic [c_CNT_W-1:0]       r_conv_cnt;
  logic                     r_serial_rx;

  logic w_armed;
  logic w_convst_s;
  logic w_sck_s;
  logic w_tx_s;
  logic w_cv_rise;
  logic w_cv_fall;
  logic w_sck_rise;
  logic w_sck_fall;

  assign w_convst_s = r_convst_sync[SYNC_STAGES-1];
  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_tx_s     = r_tx_sync[SYNC_STAGES-1];
  // Edges are masked until the synchronizers have flushed after reset, so a
  // line that was already high at release never looks like a fresh rise.
  assign w_armed    = (r_arm_cnt == 3'(c_ARM_CYCLES));
  assign w_cv_rise  = w_armed &  w_convst_s & ~r_convst_d;
  assign w_cv_fall  = w_armed & ~w_convst_s &  r_convst_d;
  assign w_sck_rise = w_armed &  w_sck_s    & ~r_sck_d;
  assign w_sck_fall = w_armed & ~w_sck_s    &  r_sck_d;

  assign bus.serial_rx = r_serial_rx;

  // Synchronize async inputs, keep previous sample for edge detection, and
  // delay i_sample by the same depth so the captured value lines up with
  // the convst pin edge rather than the later synchronized edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_convst_sync <= '0;
      r_sck_sync    <= '0;
      r_tx_sync     <= '0;
      r_convst_d    <= 1'b0;
      r_sck_d       <= 1'b0;
      r_arm_cnt     <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) r_sample_pipe[i] <= '0;
    end else begin
      r_convst_sync <= {r_convst_sync[SYNC_STAGES-2:0], bus.convst};
      r_sck_sync    <= {r_sck_sync[SYNC_STAGES-2:0], bus.sck};
      r_tx_sync     <= {r_tx_sync[SYNC_STAGES-2:0], bus.serial_tx};
      r_convst_d    <= w_convst_s;
      r_sck_d       <= w_sck_s;
      if (!w_armed) r_arm_cnt <= r_arm_cnt + 3'd1;
      r_sample_pipe[0] <= i_sample;
      for (int i = 1; i < SYNC_STAGES; i++) r_sample_pipe[i] <= r_sample_pipe[i-1];
    end
  end

  // Conversion / shift state machine with registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_cfg_sr    <= '0;
      r_cfg_pend  <= 1'b0;
      r_rise_cnt  <= '0;
      r_fall_cnt  <= '0;
      r_conv_cnt  <= '0;
      r_serial_rx <= 1'b0;
      o_cfg_bits  <= '0;
      o_cfg_dv    <= 1'b0;
      o_busy      <= 1'b0;
      o_tconv_err <= 1'b0;
    end else begin
      r_cfg_pend <= 1'b0;
      o_cfg_dv   <= 1'b0;
      // A completed six-bit word is published one cycle after the 6th rise.
      if (r_cfg_pend) begin
        o_cfg_bits <= r_cfg_sr;
        o_cfg_dv   <= 1'b1;
      end

      if (w_cv_rise) begin
        // A convst rise restarts from any state and wins over sck edges.
        r_state     <= S_CONVERTING;
        r_data      <= r_sample_pipe[SYNC_STAGES-1];
        r_cfg_sr    <= '0;
        r_rise_cnt  <= '0;
        r_fall_cnt  <= '0;
        r_conv_cnt  <= c_CNT_W'(TCONV_CYCLES - 1);
        r_serial_rx <= 1'b0;
        o_busy      <= 1'b1;
        o_tconv_err <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_serial_rx <= 1'b0;
          end
          S_CONVERTING: begin
            r_serial_rx <= 1'b0;
            if (w_cv_fall) begin
              o_tconv_err <= 1'b1;
              o_busy      <= 1'b0;
              r_serial_rx <= r_data[11];
              r_state     <= S_SHIFTING;
            end else if (r_conv_cnt == '0) begin
              o_busy  <= 1'b0;
              r_state <= S_READY;
            end else begin
              r_conv_cnt <= r_conv_cnt - 1'b1;
            end
          end
          S_READY: begin
            r_serial_rx <= 1'b0;
            if (w_cv_fall) begin
              r_serial_rx <= r_data[11];
              r_state     <= S_SHIFTING;
            end
          end
          S_SHIFTING: begin
            if (w_sck_rise) begin
              if (r_rise_cnt != 4'd12) r_rise_cnt <= r_rise_cnt + 4'd1;
              if (r_rise_cnt < 4'd6)  r_cfg_sr   <= {r_cfg_sr[4:0], w_tx_s};
              if (r_rise_cnt == 4'd5) r_cfg_pend <= 1'b1;
            end else if (w_sck_fall && (r_rise_cnt != 4'd0)) begin
              r_fall_cnt <= r_fall_cnt + 4'd1;
              if (r_fall_cnt == 4'd11) begin
                r_serial_rx <= 1'b0;
                r_state     <= S_IDLE;
              end else begin
                r_data      <= {r_data[10:0], 1'b0};
                r_serial_rx <= r_data[10];
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// | Module : tb_adc_responder                                               |
// | Desc   : Self-checking bench for adc_responder. Acts as the ADC         |
// |          controller and compares against a frame-level reference.      |
// | Rev    : 1.0  initial release                                           |
// ---------------------------------------------------------------------------
module tb_adc_responder;
  localparam int TCONV = 80;
  localparam int SYNC  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] sample = '0;
  logic [5:0]  cfg_bits;
  logic        cfg_dv;
  logic        busy;
  logic        tconv_err;

  adc_responder_if bus ();

  adc_responder #(
    .TCONV_CYCLES (TCONV),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_sample    (sample),
    .bus         (bus),
    .o_cfg_bits  (cfg_bits),
    .o_cfg_dv    (cfg_dv),
    .o_busy      (busy),
    .o_tconv_err (tconv_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int dv_total = 0;
  logic [5:0] exp_cfg = '0;

  // Count every o_cfg_dv pulse seen.
  always @(posedge clk) if (cfg_dv === 1'b1) dv_total <= dv_total + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One controller transaction: convst pulse of 'hi' cycles, then 'nper'
  // sck periods of 50 cycles, sending cfg MSB first and reading 12 bits.
  task automatic run_frame(input logic [11:0] smp, input int hi, input int nper,
                           input logic [5:0] cfg, input bit chg);
    logic [11:0] rd;
    logic [11:0] mask;
    int          nb;
    int          dv_start;
    rd       = '0;
    dv_start = dv_total;
    @(negedge clk);
    sample     = smp;
    bus.convst = 1'b1;
    tick(1);
    if (chg) sample = 12'($urandom);
    tick(9);
    check("busy_conv", 32'(busy), 32'd1);
    tick(hi - 11);
    if (hi >= TCONV + 10) check("busy_done", 32'(busy), 32'd0);
    tick(1);
    bus.convst = 1'b0;
    tick(5);
    check("busy_fall", 32'(busy), 32'd0);
    tick(15);
    for (int p = 0; p < nper; p++) begin
      bus.serial_tx = (p < 6) ? cfg[5-p] : 1'($urandom);
      tick(25);
      bus.sck = 1'b1;
      if (p < 12) rd[11-p] = bus.serial_rx;
      else check("rx_tail", 32'(bus.serial_rx), 32'd0);
      tick(25);
      bus.sck = 1'b0;
    end
    tick(10);
    nb   = (nper < 12) ? nper : 12;
    mask = 12'hFFF;
    mask = mask << (12 - nb);
    check("data", 32'(rd & mask), 32'(smp & mask));
    check("tconv_err", 32'(tconv_err), (hi < TCONV) ? 32'd1 : 32'd0);
    if (nper >= 6) exp_cfg = cfg;
    check("cfg_bits", 32'(cfg_bits), 32'(exp_cfg));
    check("dv_count", 32'(dv_total - dv_start), (nper >= 6) ? 32'd1 : 32'd0);
    if (nper >= 12) check("rx_idle", 32'(bus.serial_rx), 32'd0);
  endtask

  initial begin
    int hi;
    bus.convst    = 1'b0;
    bus.sck       = 1'b0;
    bus.serial_tx = 1'b0;
    tick(3);
    check("rst_outs", 32'({cfg_bits, cfg_dv, busy, tconv_err, bus.serial_rx}), 32'd0);
    rst_n = 1'b1;
    tick(5);

    // Directed frames: nominal, short convst, abort after 4 periods,
    // over-clocked frame of all ones, late sample change.
    run_frame(12'hA5C, 101, 12, 6'b101101, 1'b0);
    run_frame(12'h3FF, 40, 12, 6'b101101, 1'b0);
    run_frame(12'h5A3, 101, 4, 6'b010011, 1'b0);
    run_frame(12'h1C7, 101, 12, 6'b110001, 1'b0);
    run_frame(12'hFFF, 101, 16, 6'b011110, 1'b0);
    run_frame(12'h2B4, 101, 12, 6'b100110, 1'b1);

    // Randomized frames.
    for (int k = 0; k < 12; k++) begin
      hi = ($urandom_range(0, 1) == 1) ? int'($urandom_range(TCONV + 10, TCONV + 40))
                                       : int'($urandom_range(20, TCONV - 10));
      run_frame(12'($urandom), hi, int'($urandom_range(4, 16)), 6'($urandom),
                1'($urandom_range(0, 1)));
    end

    // Reset during conversion, then sck activity with convst low.
    @(negedge clk);
    bus.convst = 1'b1;
    tick(30);
    check("busy_pre_rst", 32'(busy), 32'd1);
    rst_n      = 1'b0;
    bus.convst = 1'b0;
    tick(3);
    check("rst_mid_outs", 32'({cfg_bits, cfg_dv, busy, tconv_err, bus.serial_rx}), 32'd0);
    rst_n   = 1'b1;
    exp_cfg = '0;
    for (int i = 0; i < 10; i++) begin
      bus.sck = 1'b1;
      tick(5);
      check("rx_after_rst", 32'(bus.serial_rx), 32'd0);
      bus.sck = 1'b0;
      tick(5);
      check("rx_after_rst", 32'(bus.serial_rx), 32'd0);
    end
    check("cfg_after_rst", 32'(cfg_bits), 32'(exp_cfg));

    // Convst already high when reset is released: no conversion.
    rst_n      = 1'b0;
    bus.convst = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    check("busy_masked", 32'(busy), 32'd0);
    bus.convst = 1'b0;
    tick(10);
    check("busy_masked_fall", 32'(busy), 32'd0);
    check("err_masked_fall", 32'(tconv_err), 32'd0);
    run_frame(12'h96E, 101, 12, 6'b001011, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
